// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: synchronizer, symmetric debounce,
// press/release edge pulses, one-shot long-press and optional auto-repeat.
// One shared sample counter produces the tick that paces every channel.

module button_conditioner_ch #(
    parameter int   PULSE_CNT_MAX  = 200,
    parameter int   LONG_CNT_MAX   = 2000,
    parameter int   REPEAT_CNT_MAX = 200,
    parameter logic REPEAT_ON      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic in,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);
    localparam int DW    = $clog2(PULSE_CNT_MAX + 1);
    localparam int HMAX  = (LONG_CNT_MAX > REPEAT_CNT_MAX) ? LONG_CNT_MAX : REPEAT_CNT_MAX;
    localparam int HW    = ($clog2(HMAX) < 1) ? 1 : $clog2(HMAX);

    typedef enum logic [1:0] {IDLE, HELD, LONG} hold_t;

    logic          s1, s2;
    logic [DW-1:0] dcnt;
    logic          chg, press_ev, rel_ev;
    hold_t         state, state_nxt;
    logic [HW-1:0] hcnt, hcnt_nxt;
    logic          long_ev, rep_ev;

    // Two-flop synchronizer; only s2 is ever sampled downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= in;
            s2 <= s1;
        end
    end

    // A level change is accepted on the tick that completes the disagreeing run.
    assign chg      = tick && (s2 != level) && (dcnt == DW'(PULSE_CNT_MAX - 1));
    assign press_ev = chg &&  s2;
    assign rel_ev   = chg && !s2;

    // Debounce counter and level; any agreeing sample restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt          <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= press_ev;
            release_pulse <= rel_ev;
            if (tick) begin
                if (s2 == level) begin
                    dcnt <= '0;
                end else if (chg) begin
                    level <= s2;
                    dcnt  <= '0;
                end else begin
                    dcnt <= dcnt + DW'(1);
                end
            end
        end
    end

    // Hold FSM state, hold counter and registered gesture pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hcnt         <= '0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            hcnt         <= hcnt_nxt;
            long_pulse   <= long_ev;
            repeat_pulse <= rep_ev;
        end
    end

    // Next-state logic; a release edge overrides any long/repeat event.
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        long_ev   = 1'b0;
        rep_ev    = 1'b0;
        case (state)
            IDLE: begin
                hcnt_nxt = '0;
                if (press_ev) state_nxt = HELD;
            end
            HELD: begin
                if (tick) begin
                    if (hcnt == HW'(LONG_CNT_MAX - 1)) begin
                        long_ev   = 1'b1;
                        hcnt_nxt  = '0;
                        state_nxt = LONG;
                    end else begin
                        hcnt_nxt = hcnt + HW'(1);
                    end
                end
            end
            LONG: begin
                if (tick) begin
                    if (hcnt == HW'(REPEAT_CNT_MAX - 1)) begin
                        rep_ev   = REPEAT_ON;
                        hcnt_nxt = '0;
                    end else begin
                        hcnt_nxt = hcnt + HW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                hcnt_nxt  = '0;
            end
        endcase
        if (rel_ev) begin
            state_nxt = IDLE;
            hcnt_nxt  = '0;
            long_ev   = 1'b0;
            rep_ev    = 1'b0;
        end
    end
endmodule

module button_conditioner #(
    parameter int               WIDTH          = 4,
    parameter int               SAMPLE_CNT_MAX = 50000,
    parameter int               PULSE_CNT_MAX  = 200,
    parameter int               LONG_CNT_MAX   = 2000,
    parameter int               REPEAT_CNT_MAX = 200,
    parameter logic [WIDTH-1:0] REPEAT_EN      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_pulse,
    output logic [WIDTH-1:0] repeat_pulse
);
    localparam int SW = $clog2(SAMPLE_CNT_MAX);

    logic [SW-1:0] scnt;
    logic          tick;

    assign tick = (scnt == SW'(SAMPLE_CNT_MAX - 1));

    // Free-running sample divider shared by all channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    scnt <= '0;
        else if (tick) scnt <= '0;
        else           scnt <= scnt + SW'(1);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        button_conditioner_ch #(
            .PULSE_CNT_MAX (PULSE_CNT_MAX),
            .LONG_CNT_MAX  (LONG_CNT_MAX),
            .REPEAT_CNT_MAX(REPEAT_CNT_MAX),
            .REPEAT_ON     (REPEAT_EN[i])
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .tick         (tick),
            .in           (in[i]),
            .level        (level[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .long_pulse   (long_pulse[i]),
            .repeat_pulse (repeat_pulse[i])
        );
    end
endmodule
